step4_normalize: RTL and testbench

- Consumer-side partner of the MAC pipeline's step-3 status register.
- Accepts the registered product tuple (sign, 8-bit biased exponent sum, 22-bit significand product) and normalizes it over multiple cycles with an FSM.
- Rounds round-to-nearest-even to a 1+8+10 result and presents it with overflow, underflow and zero flags.
- Uses valid/ready on both sides so the accumulate stage can back-pressure.

---
 rtl/step4_normalize.sv | 151 +++++++++++++++
 tb/tb_step4_normalize.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/step4_normalize.sv
// Multi-cycle normalizer and round-to-nearest-even stage for the MAC product tuple.
// Takes the step-3 product, normalizes the significand one bit per cycle, then rounds to a 1+8+10 result.
module step4_normalize #(
    parameter int unsigned EX_W   = 8,
    parameter int unsigned SIG_W  = 22,
    parameter int unsigned FRAC_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_out_sign,
    input  logic [EX_W-1:0]   in_ex_add_out,
    input  logic [SIG_W-1:0]  in_sig_mul_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EX_W-1:0]   out_ex,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_ovf,
    output logic              out_unf,
    output logic              out_zero
);

    localparam int unsigned XW    = EX_W + 2;
    localparam int unsigned G_BIT = SIG_W - 3 - FRAC_W;

    localparam logic signed [XW-1:0] EXP_INF  = {2'b00, {EX_W{1'b1}}};
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic signed [XW-1:0] EXP_ONE  = {{(XW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StHold} state_t;

    state_t                r_state;
    logic [SIG_W-1:0]      r_sig;
    logic signed [XW-1:0]  r_exp;
    logic                  r_sign;
    logic                  r_sticky;
    logic                  r_zero;

    logic                  r_out_valid;
    logic                  r_out_sign;
    logic [EX_W-1:0]       r_out_ex;
    logic [FRAC_W-1:0]     r_out_frac;
    logic                  r_out_ovf;
    logic                  r_out_unf;
    logic                  r_out_zero;

    logic [FRAC_W-1:0]     w_frac;
    logic                  w_guard;
    logic                  w_st;
    logic                  w_inc;
    logic [FRAC_W:0]       w_frac_sum;
    logic signed [XW-1:0]  w_exp_r;

    // Rounding datapath, valid whenever the significand sits in [1.0, 2.0).
    assign w_frac     = r_sig[SIG_W-3 -: FRAC_W];
    assign w_guard    = r_sig[G_BIT];
    assign w_st       = (|r_sig[G_BIT-1:0]) | r_sticky;
    assign w_inc      = w_guard & (w_st | w_frac[0]);
    assign w_frac_sum = {1'b0, w_frac} + {{FRAC_W{1'b0}}, w_inc};
    assign w_exp_r    = r_exp + {{(XW-1){1'b0}}, w_frac_sum[FRAC_W]};

    assign in_ready  = (r_state == StIdle);
    assign out_valid = r_out_valid;
    assign out_sign  = r_out_sign;
    assign out_ex    = r_out_ex;
    assign out_frac  = r_out_frac;
    assign out_ovf   = r_out_ovf;
    assign out_unf   = r_out_unf;
    assign out_zero  = r_out_zero;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StIdle;
            r_sig       <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_sticky    <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sign  <= 1'b0;
            r_out_ex    <= '0;
            r_out_frac  <= '0;
            r_out_ovf   <= 1'b0;
            r_out_unf   <= 1'b0;
            r_out_zero  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_sig    <= in_sig_mul_out;
                        r_exp    <= {2'b00, in_ex_add_out};
                        r_sign   <= in_out_sign;
                        r_sticky <= 1'b0;
                        r_zero   <= 1'b0;
                        r_state  <= StNorm;
                    end
                end
                StNorm: begin
                    if (r_sig == '0) begin
                        r_zero  <= 1'b1;
                        r_state <= StRound;
                    end else if (r_sig[SIG_W-1]) begin
                        r_sig    <= r_sig >> 1;
                        r_sticky <= r_sticky | r_sig[0];
                        r_exp    <= r_exp + EXP_ONE;
                        r_state  <= StRound;
                    end else if (r_sig[SIG_W-2]) begin
                        r_state <= StRound;
                    end else begin
                        r_sig <= r_sig << 1;
                        r_exp <= r_exp - EXP_ONE;
                    end
                end
                StRound: begin
                    r_out_sign  <= r_sign;
                    r_out_ovf   <= 1'b0;
                    r_out_unf   <= 1'b0;
                    r_out_zero  <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= StHold;
                    if (r_zero) begin
                        r_out_ex   <= '0;
                        r_out_frac <= '0;
                        r_out_zero <= 1'b1;
                    end else if (w_exp_r >= EXP_INF) begin
                        r_out_ex   <= {EX_W{1'b1}};
                        r_out_frac <= '0;
                        r_out_ovf  <= 1'b1;
                    end else if (w_exp_r <= EXP_ZERO) begin
                        r_out_ex   <= '0;
                        r_out_frac <= '0;
                        r_out_unf  <= 1'b1;
                    end else begin
                        r_out_ex   <= w_exp_r[EX_W-1:0];
                        r_out_frac <= w_frac_sum[FRAC_W-1:0];
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_step4_normalize.sv
// Directed vector bench for step4_normalize: result values, latency, back-pressure and reset abort.
module tb_step4_normalize;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_out_sign;
    logic [7:0]  in_ex_add_out;
    logic [21:0] in_sig_mul_out;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_ex;
    logic [9:0]  out_frac;
    logic        out_ovf;
    logic        out_unf;
    logic        out_zero;

    int n_vec;
    int n_err;

    step4_normalize dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_out_sign    (in_out_sign),
        .in_ex_add_out  (in_ex_add_out),
        .in_sig_mul_out (in_sig_mul_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sign       (out_sign),
        .out_ex         (out_ex),
        .out_frac       (out_frac),
        .out_ovf        (out_ovf),
        .out_unf        (out_unf),
        .out_zero       (out_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        sign;
        logic [7:0]  ex;
        logic [21:0] sig;
        logic        e_sign;
        logic [7:0]  e_ex;
        logic [9:0]  e_frac;
        logic        e_ovf;
        logic        e_unf;
        logic        e_zero;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic accept(input logic s, input logic [7:0] e, input logic [21:0] g);
        @(negedge clock);
        in_valid       = 1'b1;
        in_out_sign    = s;
        in_ex_add_out  = e;
        in_sig_mul_out = g;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("in_ready_after_accept", in_ready, 0);
    endtask

    // Counts edges after the accept edge until out_valid rises, bounded at 40.
    task automatic wait_valid(input int exp_lat, input string nm);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clock);
            #1;
            n++;
            chk({nm, "_in_ready_busy"}, in_ready, 0);
        end
        chk({nm, "_latency"}, n, exp_lat);
    endtask

    task automatic handshake(input string nm);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk({nm, "_valid_drop"}, out_valid, 0);
        chk({nm, "_in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_out_sign    = 1'b0;
        in_ex_add_out  = '0;
        in_sig_mul_out = '0;
        out_ready      = 1'b0;

        //         sign ex    sig         esgn eex    efrac   ovf  unf  zero lat
        vecs[0]  = '{1'b0, 8'd127, 22'h100000, 1'b0, 8'd127, 10'h000, 1'b0, 1'b0, 1'b0, 2};
        vecs[1]  = '{1'b0, 8'd127, 22'h300000, 1'b0, 8'd128, 10'h200, 1'b0, 1'b0, 1'b0, 2};
        vecs[2]  = '{1'b0, 8'd127, 22'h100600, 1'b0, 8'd127, 10'h002, 1'b0, 1'b0, 1'b0, 2};
        vecs[3]  = '{1'b0, 8'd127, 22'h100200, 1'b0, 8'd127, 10'h000, 1'b0, 1'b0, 1'b0, 2};
        vecs[4]  = '{1'b0, 8'd140, 22'h000400, 1'b0, 8'd130, 10'h000, 1'b0, 1'b0, 1'b0, 12};
        vecs[5]  = '{1'b0, 8'd254, 22'h3FFFFF, 1'b0, 8'hFF,  10'h000, 1'b1, 1'b0, 1'b0, 2};
        vecs[6]  = '{1'b0, 8'd1,   22'h080000, 1'b0, 8'd0,   10'h000, 1'b0, 1'b1, 1'b0, 3};
        vecs[7]  = '{1'b1, 8'd127, 22'h000000, 1'b1, 8'd0,   10'h000, 1'b0, 1'b0, 1'b1, 2};
        vecs[8]  = '{1'b0, 8'd100, 22'h1FFE00, 1'b0, 8'd101, 10'h000, 1'b0, 1'b0, 1'b0, 2};
        vecs[9]  = '{1'b1, 8'd130, 22'h140000, 1'b1, 8'd130, 10'h100, 1'b0, 1'b0, 1'b0, 2};
        // Bit 0 shifted out becomes sticky and breaks the tie upward.
        vecs[10] = '{1'b0, 8'd127, 22'h300401, 1'b0, 8'd128, 10'h201, 1'b0, 1'b0, 1'b0, 2};

        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ex", out_ex, 0);
        chk("rst_out_frac", out_frac, 0);
        chk("rst_flags", {out_sign, out_ovf, out_unf, out_zero}, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            accept(vecs[i].sign, vecs[i].ex, vecs[i].sig);
            wait_valid(vecs[i].lat, $sformatf("v%0d", i));
            chk($sformatf("v%0d_sign", i), out_sign, vecs[i].e_sign);
            chk($sformatf("v%0d_ex", i), out_ex, vecs[i].e_ex);
            chk($sformatf("v%0d_frac", i), out_frac, vecs[i].e_frac);
            chk($sformatf("v%0d_ovf", i), out_ovf, vecs[i].e_ovf);
            chk($sformatf("v%0d_unf", i), out_unf, vecs[i].e_unf);
            chk($sformatf("v%0d_zero", i), out_zero, vecs[i].e_zero);
            handshake($sformatf("v%0d", i));
            chk($sformatf("v%0d_ex_kept", i), out_ex, vecs[i].e_ex);
        end

        // Back-pressure: hold out_ready low with a competing request pending.
        accept(1'b0, 8'd127, 22'h300000);
        wait_valid(2, "bp");
        @(negedge clock);
        in_valid       = 1'b1;
        in_out_sign    = 1'b0;
        in_ex_add_out  = 8'd50;
        in_sig_mul_out = 22'h100000;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            chk("bp_valid_held", out_valid, 1);
            chk("bp_ex_stable", out_ex, 8'd128);
            chk("bp_frac_stable", out_frac, 10'h200);
            chk("bp_in_ready_low", in_ready, 0);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk("bp_hs_valid_drop", out_valid, 0);
        chk("bp_hs_in_ready", in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("bp_second_accepted", in_ready, 0);
        wait_valid(2, "bp2");
        chk("bp2_ex", out_ex, 8'd50);
        chk("bp2_frac", out_frac, 10'h000);

        // Reset while the ex=140 case is still shifting in NORM.
        handshake("bp2");
        accept(1'b0, 8'd140, 22'h000400);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_ex", out_ex, 0);
        chk("abort_out_frac", out_frac, 0);
        chk("abort_flags", {out_sign, out_ovf, out_unf, out_zero}, 0);
        @(negedge clock);
        reset = 1'b0;

        accept(1'b0, 8'd127, 22'h300000);
        wait_valid(2, "post_rst");
        chk("post_rst_ex", out_ex, 8'd128);
        chk("post_rst_frac", out_frac, 10'h200);
        handshake("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
